// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM tag verifier.
//   GCM_BLK_W   : GHASH block width in bits.
//   GCM_R       : GF(2^128) reduction constant (0xE1 << 120) in GCM bit order.
//   gcm_state_t : verifier FSM states.
package gcm_pkg;

  localparam int GCM_BLK_W = 128;
  localparam logic [GCM_BLK_W-1:0] GCM_R = {8'he1, 120'd0};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    MULT     = 2'd2,
    FINAL    = 2'd3
  } gcm_state_t;

endpackage

// File: rtl/ghash_digit_step.sv
// One DIGIT-bit slice of the GF(2^128) shift-and-add multiply.
//   z_in / v_in   : running product and shifted multiplicand before this slice
//   x_dig         : next DIGIT multiplier bits, x_dig[DIGIT-1] consumed first
//   z_out / v_out : running product and multiplicand after this slice
// Purely combinational.
module ghash_digit_step
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [GCM_BLK_W-1:0] z_in,
  input  logic [GCM_BLK_W-1:0] v_in,
  input  logic [DIGIT-1:0]     x_dig,
  output logic [GCM_BLK_W-1:0] z_out,
  output logic [GCM_BLK_W-1:0] v_out
);

  logic [GCM_BLK_W-1:0] z_t;
  logic [GCM_BLK_W-1:0] v_t;

  always_comb begin
    z_t = z_in;
    v_t = v_in;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      if (x_dig[i]) z_t = z_t ^ v_t;
      // GCM bit order: shifting right multiplies by x; a bit falling off
      // the end folds back through the reduction polynomial.
      v_t = (v_t >> 1) ^ (v_t[0] ? GCM_R : '0);
    end
    z_out = z_t;
    v_out = v_t;
  end

endmodule

// File: rtl/gcm_tag_verify.sv
// GCM tag verifier: runs GHASH over a block stream, forms T = GHASH ^ E(K,J0)
// and compares it against a received tag.
// Ports:
//   clk, rst (async, active-high)
//   start, h_key, ek_j0, tag_in : begin a message and latch its operands
//   blk_valid/blk_ready/blk_data/blk_last : block stream, blk_last marks the
//                                           length block
//   busy, done, tag_ok           : status, one-cycle verdict pulse, verdict
//   tag_out                      : computed tag (only with GCM_TAG_OUT_EN)
//   state_dbg                    : current FSM state
// Build option: define GCM_TAG_OUT_EN to expose the computed tag on tag_out;
// otherwise tag_out is tied to zero and no tag register exists.
//
// Handshake: a block transfers on a rising edge where blk_valid and blk_ready
// are both 1. blk_ready is 1 only in WAIT_BLK; blk_valid is ignored
// elsewhere, so a source may hold it high across the multiply.
module gcm_tag_verify
  import gcm_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [GCM_BLK_W-1:0] h_key,
  input  logic [GCM_BLK_W-1:0] ek_j0,
  input  logic [GCM_BLK_W-1:0] tag_in,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [GCM_BLK_W-1:0] blk_data,
  input  logic                 blk_last,
  output logic                 busy,
  output logic                 done,
  output logic                 tag_ok,
  output logic [GCM_BLK_W-1:0] tag_out,
  output gcm_state_t           state_dbg
);

  localparam int N_STEPS = GCM_BLK_W / DIGIT;
  localparam logic [7:0] LAST_STEP = 8'(N_STEPS - 1);

  gcm_state_t           state_q, state_d;
  logic [GCM_BLK_W-1:0] h_q, h_d;
  logic [GCM_BLK_W-1:0] ek_q, ek_d;
  logic [GCM_BLK_W-1:0] tin_q, tin_d;
  logic [GCM_BLK_W-1:0] y_q, y_d;
  logic [GCM_BLK_W-1:0] x_q, x_d;
  logic [GCM_BLK_W-1:0] z_q, z_d;
  logic [GCM_BLK_W-1:0] v_q, v_d;
  logic                 last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 tag_ok_q, tag_ok_d;

  logic [GCM_BLK_W-1:0] z_step;
  logic [GCM_BLK_W-1:0] v_step;
  logic [GCM_BLK_W-1:0] t_val;
  logic                 tag_match;

  // Multiplier bits are consumed MSB first; x_q shifts left every cycle.
  ghash_digit_step #(.DIGIT(DIGIT)) u_step (
    .z_in  (z_q),
    .v_in  (v_q),
    .x_dig (x_q[GCM_BLK_W-1 -: DIGIT]),
    .z_out (z_step),
    .v_out (v_step)
  );

  assign t_val     = y_q ^ ek_q;
  // Full-width equality: every bit participates, no early exit.
  assign tag_match = (t_val == tin_q);

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    ek_d     = ek_q;
    tin_d    = tin_q;
    y_d      = y_q;
    x_d      = x_q;
    z_d      = z_q;
    v_d      = v_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tag_ok_d = tag_ok_q;
    if (start) begin
      // start wins over everything, including an in-flight multiply.
      state_d  = WAIT_BLK;
      h_d      = h_key;
      ek_d     = ek_j0;
      tin_d    = tag_in;
      y_d      = '0;
      x_d      = '0;
      z_d      = '0;
      v_d      = '0;
      last_d   = 1'b0;
      cnt_d    = '0;
      tag_ok_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_BLK: begin
          if (blk_valid) begin
            x_d     = y_q ^ blk_data;
            z_d     = '0;
            v_d     = h_q;
            last_d  = blk_last;
            cnt_d   = '0;
            state_d = MULT;
          end
        end
        MULT: begin
          z_d   = z_step;
          v_d   = v_step;
          x_d   = x_q << DIGIT;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_STEP) begin
            y_d     = z_step;
            state_d = last_q ? FINAL : WAIT_BLK;
          end
        end
        FINAL: begin
          tag_ok_d = tag_match;
          state_d  = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      h_q      <= '0;
      ek_q     <= '0;
      tin_q    <= '0;
      y_q      <= '0;
      x_q      <= '0;
      z_q      <= '0;
      v_q      <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      tag_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      ek_q     <= ek_d;
      tin_q    <= tin_d;
      y_q      <= y_d;
      x_q      <= x_d;
      z_q      <= z_d;
      v_q      <= v_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tag_ok_q <= tag_ok_d;
    end
  end

  assign blk_ready = (state_q == WAIT_BLK);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINAL);
  // The verdict is live during the FINAL cycle so it is valid alongside
  // done; the registered copy holds it afterwards.
  assign tag_ok    = done ? tag_match : tag_ok_q;
  assign state_dbg = state_q;

`ifdef GCM_TAG_OUT_EN
  logic [GCM_BLK_W-1:0] tag_out_q, tag_out_d;

  always_comb begin
    tag_out_d = tag_out_q;
    if (start)                  tag_out_d = '0;
    else if (state_q == FINAL)  tag_out_d = t_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_out_q <= '0;
    else     tag_out_q <= tag_out_d;
  end

  assign tag_out = done ? t_val : tag_out_q;
`else
  assign tag_out = '0;
`endif

endmodule

// File: doc/gcm_tag_verify.md
GCM_TAG_VERIFY -- requirements
Module: gcm_tag_verify

Interface
REQ-001 SHALL have parameter DIGIT, default 8: GF multiplier bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64, 128.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a message; latches h_key, ek_j0 and tag_in, and clears the accumulator.
REQ-005 SHALL have port h_key, input, 128: hash key H.
REQ-006 SHALL have port ek_j0, input, 128: E(K,J0).
REQ-007 SHALL have port tag_in, input, 128: received tag to check.
REQ-008 SHALL have port blk_valid, input, 1: blk_data is valid.
REQ-009 SHALL have port blk_ready, output, 1: engine can accept a block.
REQ-010 SHALL have port blk_data, input, 128: AAD, ciphertext or length block.
REQ-011 SHALL have port blk_last, input, 1: marks the current block as the length block.
REQ-012 SHALL have port busy, output, 1: a message is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the verdict is valid.
REQ-014 SHALL have port tag_ok, output, 1: verdict; 1 means the computed tag equals tag_in.
REQ-015 SHALL have port tag_out, output, 128: computed tag (see Configuration).

Function
REQ-016 SHALL run an FSM with states IDLE, WAIT_BLK, MULT and FINAL.
REQ-017 SHALL, on start in any state, set Y=0, latch the operands, clear tag_ok and enter WAIT_BLK; start overrides all other inputs in that cycle.
REQ-018 SHALL drive blk_ready=1 only in WAIT_BLK; a block transfers when blk_valid and blk_ready are both 1.
REQ-019 SHALL, on transfer, load X=Y^blk_data, Z=0 and V=H, register blk_last, and enter MULT.
REQ-020 SHALL spend exactly 128/DIGIT cycles in MULT, DIGIT bits per cycle, MSB first.
- Per bit, starting at X[127]: if the bit is 1, Z^=V.
- V = V>>1, XORed with 0xE1<<120 when the old V[0]=1.
REQ-021 SHALL, after the last MULT cycle, set Y=Z and enter FINAL if blk_last was registered, otherwise WAIT_BLK.
- Transfer in cycle T gives blk_ready=1 again at T+128/DIGIT+1.
REQ-022 SHALL, in FINAL:
- compute T=Y^ek_j0;
- register tag_ok=(T==tag_in) using a full 128-bit compare with no early exit;
- pulse done for exactly one cycle;
- enter IDLE.
REQ-023 SHALL hold tag_ok until the next start or reset.
REQ-024 SHALL assert busy in WAIT_BLK, MULT and FINAL.
REQ-025 SHALL ignore blk_valid in IDLE, MULT and FINAL.
REQ-026 SHALL ignore changes to h_key, ek_j0 and tag_in after start.
REQ-027 SHALL, when start arrives during MULT, abort the multiplication with no done pulse.

Reset
REQ-028 SHALL, on rst, go asynchronously to IDLE with blk_ready=0, busy=0, done=0, tag_ok=0, tag_out=0 and all internal registers 0.
REQ-029 SHALL, on rst mid-message, discard the message; done SHALL NOT pulse.

Configuration
REQ-030 SHALL use macro GCM_TAG_OUT_EN.
- Defined: tag_out SHALL carry T, registered in FINAL, and hold until the next start or rst, which clear it to 0.
- Undefined: tag_out SHALL be constant 0 and no T register SHALL exist, so the tag is never exposed.

Structure
REQ-031 SHALL take the constants GCM_R (0xE1<<120) and GCM_BLK_W (128) and the FSM state enum from shared package gcm_pkg.
REQ-032 SHALL place the DIGIT-bit multiply step in sub-module ghash_digit_step.
- Combinational; inputs Z, V and X-digit; outputs Z' and V'.

Verification
REQ-033 SHALL cover NIST case 1.
- Stimulus: H=66e94bd4ef8a2c3b884cfa59ca342b2e, ek_j0=58e2fccefa7e3061367f1d57a4e7455a, tag_in=58e2fccefa7e3061367f1d57a4e7455a; one last block of all zeros.
- Required: done after 128/DIGIT+1 cycles, tag_ok=1.
REQ-034 SHALL cover NIST case 2.
- Stimulus: same H and ek_j0; block 0388dace60b6a392f328c2b971b2fe78, then last block 0...0080; tag_in=ab6e47d42cec13bdf53a67b21257bddf.
- Required: tag_ok=1, and tag_out equals that tag when GCM_TAG_OUT_EN is defined.
REQ-035 SHALL cover a wrong tag: case 2 with tag_in bit 0 flipped -> tag_ok=0 and done pulses once.
REQ-036 SHALL cover backpressure: blk_valid held high during MULT -> no extra transfer; exactly 2 transfers in case 2.
REQ-037 SHALL cover aborts.
- start during MULT of case 2, then a clean case 1 -> tag_ok=1.
- rst mid-message -> all outputs 0, no done pulse.
REQ-038 SHALL repeat REQ-033 to REQ-034 with DIGIT=1 and DIGIT=128 -> identical verdicts, latency 129 and 2 cycles respectively.
